// File: rtl/display_pkg.sv
// -----------------------------------------------------------------------------
// display_pkg
// Shared constants and types for the step-tracker display output stage:
//   - active-low seven-segment patterns (bit 0 = segment a ... bit 6 = g)
//   - blank pattern, page index constants, saturation limit
//   - converter FSM state type and the nibble-to-segment decoder
// -----------------------------------------------------------------------------
package display_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  localparam logic [6:0] SEG_0 = 7'h40;
  localparam logic [6:0] SEG_1 = 7'h79;
  localparam logic [6:0] SEG_2 = 7'h24;
  localparam logic [6:0] SEG_3 = 7'h30;
  localparam logic [6:0] SEG_4 = 7'h19;
  localparam logic [6:0] SEG_5 = 7'h12;
  localparam logic [6:0] SEG_6 = 7'h02;
  localparam logic [6:0] SEG_7 = 7'h78;
  localparam logic [6:0] SEG_8 = 7'h00;
  localparam logic [6:0] SEG_9 = 7'h10;

  localparam logic [1:0] PG_STEPS   = 2'd0;
  localparam logic [1:0] PG_MILES   = 2'd1;
  localparam logic [1:0] PG_OVER32  = 2'd2;
  localparam logic [1:0] PG_HIGHACT = 2'd3;

  // Largest value the four decimal digits can show.
  localparam logic [13:0] SAT_MAX = 14'd9999;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SHIFT,
    ST_DONE
  } conv_state_t;

  function automatic logic [6:0] seg_decode(input logic [3:0] nib);
    logic [6:0] pat;
    case (nib)
      4'd0:    pat = SEG_0;
      4'd1:    pat = SEG_1;
      4'd2:    pat = SEG_2;
      4'd3:    pat = SEG_3;
      4'd4:    pat = SEG_4;
      4'd5:    pat = SEG_5;
      4'd6:    pat = SEG_6;
      4'd7:    pat = SEG_7;
      4'd8:    pat = SEG_8;
      4'd9:    pat = SEG_9;
      default: pat = SEG_BLANK;
    endcase
    return pat;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// -----------------------------------------------------------------------------
// bin2bcd_seq
// Sequential 14-bit binary to 4-digit BCD converter (shift-add-3).
// Sequence: IDLE -> LOAD -> 14 x SHIFT -> DONE -> IDLE.
// Ports:
//   CLK, RESET   clock and synchronous active-high reset
//   start        begin a conversion when idle
//   abort        drop the conversion in flight and reload next cycle
//   bin[13:0]    binary value, captured in LOAD
//   done         high for the single DONE cycle; bcd is valid then
//   bcd[15:0]    four BCD nibbles, thousands in [15:12]
// -----------------------------------------------------------------------------
module bin2bcd_seq
  import display_pkg::*;
(
  input  logic        CLK,
  input  logic        RESET,
  input  logic        start,
  input  logic        abort,
  input  logic [13:0] bin,
  output logic        done,
  output logic [15:0] bcd
);

  conv_state_t r_state;
  logic [13:0] r_bin;
  logic [15:0] r_bcd;
  logic [3:0]  r_cnt;
  logic [15:0] w_adj;

  // Add 3 to every nibble that is 5 or more before it is doubled by the shift.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_adj
      assign w_adj[gi*4 +: 4] = (r_bcd[gi*4 +: 4] >= 4'd5) ? (r_bcd[gi*4 +: 4] + 4'd3)
                                                           : r_bcd[gi*4 +: 4];
    end
  endgenerate

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state <= ST_IDLE;
      r_bin   <= '0;
      r_bcd   <= '0;
      r_cnt   <= '0;
    end else if (abort) begin
      // Restart from LOAD so the next capture sees the new input.
      r_state <= ST_LOAD;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) r_state <= ST_LOAD;
        end
        ST_LOAD: begin
          r_bin   <= bin;
          r_bcd   <= '0;
          r_cnt   <= '0;
          r_state <= ST_SHIFT;
        end
        ST_SHIFT: begin
          r_bcd <= {w_adj[14:0], r_bin[13]};
          r_bin <= {r_bin[12:0], 1'b0};
          if (r_cnt == 4'd13) r_state <= ST_DONE;
          else                r_cnt   <= r_cnt + 4'd1;
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign done = (r_state == ST_DONE);
  assign bcd  = r_bcd;

endmodule

// File: rtl/display_cycler.sv
// -----------------------------------------------------------------------------
// display_cycler
// Rotates four 14-bit readouts across a 4-digit seven-segment display.
// Parameters: CLK_HZ (clock Hz), DWELL_SEC (seconds per page),
//             SCAN_DIV (cycles each digit stays lit).
// Ports:
//   CLK, RESET                    clock, synchronous active-high reset
//   STEPS, MILES, OVER32, HIGHACT readouts for pages 0..3
//   PAGE                          page currently shown
//   AN0..AN3                      active-low anodes, AN0 rightmost
//   SEG                           active-low segments, SEG[0]=a .. SEG[6]=g
// Each page keeps its own last complete BCD result, so a revisited page shows
// immediately; a page is blank only until its first conversion completes.
// -----------------------------------------------------------------------------
module display_cycler
  import display_pkg::*;
#(
  parameter int CLK_HZ    = 100_000_000,
  parameter int DWELL_SEC = 2,
  parameter int SCAN_DIV  = 100_000
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [13:0] STEPS,
  input  logic [13:0] MILES,
  input  logic [13:0] OVER32,
  input  logic [13:0] HIGHACT,
  output logic [1:0]  PAGE,
  output logic        AN0,
  output logic        AN1,
  output logic        AN2,
  output logic        AN3,
  output logic [6:0]  SEG
);

  localparam int DWELL_CYC = CLK_HZ * DWELL_SEC;
  localparam int DWELL_W   = (DWELL_CYC > 1) ? $clog2(DWELL_CYC) : 1;
  localparam int SCAN_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DWELL_W-1:0] DWELL_LAST = DWELL_W'(DWELL_CYC - 1);
  localparam logic [SCAN_W-1:0]  SCAN_LAST  = SCAN_W'(SCAN_DIV - 1);

  logic [DWELL_W-1:0] r_dwell;
  logic [SCAN_W-1:0]  r_scan;
  logic [1:0]         r_page;
  logic [1:0]         r_idx;
  logic [3:0]         r_an;
  logic [6:0]         r_seg;
  logic [15:0]        r_disp [4];
  logic [3:0]         r_valid;

  logic        w_page_tick;
  logic        w_scan_tick;
  logic [13:0] w_raw;
  logic [13:0] w_sat;
  logic        w_done;
  logic [15:0] w_bcd;
  logic [15:0] w_cur;
  logic [3:0]  w_lz;
  logic [3:0]  w_nib;
  logic        w_blank;

  assign w_page_tick = (r_dwell == DWELL_LAST);
  assign w_scan_tick = (r_scan == SCAN_LAST);

  always_comb begin
    w_raw = STEPS;
    case (r_page)
      PG_STEPS:   w_raw = STEPS;
      PG_MILES:   w_raw = MILES;
      PG_OVER32:  w_raw = OVER32;
      PG_HIGHACT: w_raw = HIGHACT;
      default:    w_raw = STEPS;
    endcase
  end

  assign w_sat = (w_raw > SAT_MAX) ? SAT_MAX : w_raw;

  // The page tick doubles as the abort: the FSM reloads on the same edge that
  // PAGE advances, so LOAD captures the new page's value.
  bin2bcd_seq u_conv (
    .CLK   (CLK),
    .RESET (RESET),
    .start (1'b1),
    .abort (w_page_tick),
    .bin   (w_sat),
    .done  (w_done),
    .bcd   (w_bcd)
  );

  // Leading-zero flags: a digit is a leading zero if it and all higher
  // digits are zero. The ones digit is never blanked.
  assign w_cur   = r_disp[r_page];
  assign w_lz[3] = (w_cur[15:12] == 4'd0);
  assign w_lz[0] = 1'b0;
  generate
    for (genvar gi = 1; gi < 3; gi++) begin : g_lz
      assign w_lz[gi] = w_lz[gi+1] & (w_cur[gi*4 +: 4] == 4'd0);
    end
  endgenerate

  assign w_nib   = w_cur[r_idx*4 +: 4];
  assign w_blank = ~r_valid[r_page] | w_lz[r_idx];

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_dwell <= '0;
      r_scan  <= '0;
      r_page  <= PG_STEPS;
      r_idx   <= '0;
      r_an    <= 4'b1111;
      r_seg   <= SEG_BLANK;
      r_valid <= '0;
      for (int i = 0; i < 4; i++) r_disp[i] <= '0;
    end else begin
      if (w_page_tick) begin
        r_dwell <= '0;
        r_page  <= r_page + 2'd1;
      end else begin
        r_dwell <= r_dwell + DWELL_W'(1);
      end

      if (w_scan_tick) begin
        r_scan <= '0;
        r_idx  <= r_idx + 2'd1;
      end else begin
        r_scan <= r_scan + SCAN_W'(1);
      end

      // A result finishing on the page-tick cycle belongs to the outgoing
      // page's aborted run window and is dropped.
      if (w_done && !w_page_tick) begin
        r_disp[r_page]  <= w_bcd;
        r_valid[r_page] <= 1'b1;
      end

      r_an  <= ~(4'b0001 << r_idx);
      r_seg <= w_blank ? SEG_BLANK : seg_decode(w_nib);
    end
  end

  assign PAGE = r_page;
  assign AN0  = r_an[0];
  assign AN1  = r_an[1];
  assign AN2  = r_an[2];
  assign AN3  = r_an[3];
  assign SEG  = r_seg;

endmodule
